aria_diff_seq: RTL and testbench
================================

// Module: aria_diff_seq
// PURPOSE
//  Parametrised, self-sequencing ARIA diffusion (DIFF) layer for the round datapath.
//  - Processes a captured 128-bit state as four 32-bit word steps, LANES steps per clock.
//  - Owns its step counter, source shift register, start/busy/done handshake and
//    per-step permutation pattern.
//  - Also supports the XOR-feedback preload path and synchronous clear.
//  Sits between the S-box layer and the round-key XOR in the ARIA round core.
// PARAMETERS
//  LANES  1  word steps per clock; legal values 1, 2, 4; any other value is an elaboration error
//  (derived) NCYC = 4/LANES  clocks per operation
// PORTS
//  clk       in   1    clock, rising edge
//  rst_n     in   1    asynchronous reset, active low
//  start     in   1    begin DIFF operation; accepted only when busy=0
//  dir       in   1    0: MSB word first, shift left; 1: LSB word first, shift right (key-diff mode)
//  perm_pat  in   4    bit k = permutation for step k (1 = even/byte-reverse, 0 = odd)
//  din       in   128  source state, captured on accepted start; also xfb operand
//  acc_clr   in   1    synchronous clear of accumulator; aborts an operation in progress
//  xfb_load  in   1    when idle: acc <= din ^ xfb_din
//  xfb_din   in   128  feedback operand
//  busy      out  1    operation in progress
//  done      out  1    one-cycle pulse; dout holds the final result that cycle
//  dout      out  128  accumulator register (acc), always visible
// BEHAVIOUR
//  Reset: acc=0, src=0, cnt=0, busy=0, done=0; captured dir/perm_pat = 0.
//  One word step, with w = src[127:96] (dir=0) or src[31:0] (dir=1), w = {t0,t1,t2,t3}:
//   ty = {t1^t2, t0^t3, t0^t3, t1^t2, t2^t3, t2^t3, t0^t1, t0^t1,
//         t1^t3, t0^t2, t1^t3, t0^t2, t0, t1, t2, t3}
//   z  = ty ^ acc, bytes z0..z15 (z0 = MSB)
//   even: acc <= {z15..z0} (full byte reverse)
//   odd : acc <= {z6,z7,z4,z5,z2,z3,z0,z1,z14,z15,z12,z13,z10,z11,z8,z9}
//   Then src shifts 32 bits: left when dir=0, right when dir=1; zero fill.
//  Per clock while busy: LANES steps chained combinationally. Step indices are
//   cnt*LANES .. cnt*LANES+LANES-1; perm_pat bit = step index.
//  Handshake and timing:
//   - Start accepted at edge E0: src <= din; dir and perm_pat captured; cnt <= 0; busy <= 1.
//     acc is NOT cleared; accumulation continues from the current acc.
//   - Edges E1..E_NCYC perform the steps.
//   - At E_NCYC: busy <= 0 and done <= 1 for exactly one cycle.
//   - Latency: done is high NCYC edges after acceptance. Next start is accepted in the done cycle.
//  Priority per edge: acc_clr > step (busy) > start > xfb_load.
//   - acc_clr: acc=0, busy=0, cnt=0; no done; any pending done is suppressed.
//   - start while busy: ignored.
//   - xfb_load while busy: ignored.
//   - start and xfb_load together while idle: start wins; xfb ignored.
//  dir, perm_pat and din changes while busy have no effect.
//  Reset asserted mid-operation: return to reset state immediately; no done.
// TESTING
//  T1 LANES=4, acc=0, din=0, start -> done one cycle after acceptance, dout=0, busy high exactly 1 cycle.
//  T2 LANES=1, acc=0, dir=0, din=01020304_00000000_00000000_00000000, perm_pat=4'b1111
//     -> done after 4 clocks, dout=01050501_07070303_06020602_01020304; repeat with perm_pat=4'b0000 -> same value.
//  T3 as T2 with perm_pat=4'b0001 -> dout=02060206_02010403_05010105_07070303; run for LANES=1,2,4.
//  T4 dir=1, din=00000000_00000000_00000000_01020304, perm_pat=4'b1111 -> dout=01050501_07070303_06020602_01020304.
//  T5 idle, xfb_load, din=FF..FF, xfb_din=0F..0F -> acc=F0..F0 next cycle.
//     - Then start with din=0, perm_pat=4'b1111 -> dout=F0..F0 (byte reverse applied 4 times).
//     - xfb_load asserted while busy -> ignored.
//  T6 acc_clr mid-operation (LANES=1, 2nd step) -> dout=0, busy=0, no done pulse.
//     - start pulsed while busy -> no effect.
//     - rst_n low mid-operation -> all outputs 0.

Source files
------------

// File: rtl/aria_diff_seq.sv
// ARIA diffusion layer with its own step sequencer: four 32-bit word steps
// per operation, LANES steps chained per clock, start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; xfb_load may preload acc
// ST_RUN  | stepping, LANES word steps per clock
module aria_diff_seq #(
    parameter int LANES = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_dir,
    input  logic [3:0]   i_perm_pat,
    input  logic [127:0] i_din,
    input  logic         i_acc_clr,
    input  logic         i_xfb_load,
    input  logic [127:0] i_xfb_din,
    output logic         o_busy,
    output logic         o_done,
    output logic [127:0] o_dout
);

    localparam int NCYC = 4 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("aria_diff_seq: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_done_nxt;
    logic           w_last;
    logic           r_done;
    logic           r_dir;
    logic [3:0]     r_pat;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_acc;
    logic [127:0]   r_src;
    logic [127:0]   w_acc_nxt;
    logic [127:0]   w_src_nxt;
    logic [1:0]     w_idx;
    logic [31:0]    w_word;

    // One diffusion word step: expand word, fold into acc, permute bytes.
    function automatic logic [127:0] diff_step(input logic [31:0]  w,
                                               input logic [127:0] acc,
                                               input logic         even);
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] ty;
        logic [127:0] z;
        logic [7:0]   zb [16];
        logic [127:0] res;
        t0 = w[31:24];
        t1 = w[23:16];
        t2 = w[15:8];
        t3 = w[7:0];
        ty = {t1 ^ t2, t0 ^ t3, t0 ^ t3, t1 ^ t2, t2 ^ t3, t2 ^ t3, t0 ^ t1, t0 ^ t1,
              t1 ^ t3, t0 ^ t2, t1 ^ t3, t0 ^ t2, t0, t1, t2, t3};
        z  = ty ^ acc;
        for (int k = 0; k < 16; k++) begin
            zb[k] = z[127-8*k -: 8];
        end
        res = '0;
        if (even) begin
            for (int k = 0; k < 16; k++) begin
                res[127-8*k -: 8] = zb[15-k];
            end
        end else begin
            res = {zb[6],  zb[7],  zb[4],  zb[5],  zb[2],  zb[3],  zb[0],  zb[1],
                   zb[14], zb[15], zb[12], zb[13], zb[10], zb[11], zb[8],  zb[9]};
        end
        return res;
    endfunction

    // LANES steps chained combinationally; step index selects the perm bit.
    always_comb begin
        w_acc_nxt = r_acc;
        w_src_nxt = r_src;
        w_idx     = '0;
        w_word    = '0;
        for (int l = 0; l < LANES; l++) begin
            w_idx     = 2'(int'(r_cnt) * LANES + l);
            w_word    = r_dir ? w_src_nxt[31:0] : w_src_nxt[127:96];
            w_acc_nxt = diff_step(w_word, w_acc_nxt, r_pat[w_idx]);
            w_src_nxt = r_dir ? {32'h0, w_src_nxt[127:32]} : {w_src_nxt[95:0], 32'h0};
        end
    end

    assign w_last = (r_cnt == CW'(NCYC - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_acc_clr && i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_acc_clr) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: clear beats stepping, stepping beats start, start beats preload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_src <= '0;
            r_cnt <= '0;
            r_dir <= 1'b0;
            r_pat <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_nxt;
            r_src <= w_src_nxt;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end else if (i_start) begin
            r_src <= i_din;
            r_dir <= i_dir;
            r_pat <= i_perm_pat;
            r_cnt <= '0;
        end else if (i_xfb_load) begin
            r_acc <= i_din ^ i_xfb_din;
        end
    end

    assign o_busy = (r_state == ST_RUN);
    assign o_done = r_done;
    assign o_dout = r_acc;

endmodule

// File: tb/tb_aria_diff_seq.sv
// Directed bench for aria_diff_seq: three instances (LANES = 1, 2, 4) share
// stimulus and are checked against hand-computed results and latencies.
module tb_aria_diff_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         dir;
    logic [3:0]   perm_pat;
    logic [127:0] din;
    logic         acc_clr;
    logic         xfb_load;
    logic [127:0] xfb_din;
    logic         busy [3];
    logic         done [3];
    logic [127:0] dout [3];

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] A_MSB   = 128'h01020304_00000000_00000000_00000000;
    localparam logic [127:0] B_LSB   = 128'h00000000_00000000_00000000_01020304;
    localparam logic [127:0] EXP_T2  = 128'h01050501_07070303_06020602_01020304;
    localparam logic [127:0] EXP_T3  = 128'h02060206_02010403_05010105_07070303;
    localparam logic [127:0] EXP_S0  = 128'h04030201_02060206_03030707_01050501;
    localparam logic [127:0] ONES    = {16{8'hFF}};
    localparam logic [127:0] X0F     = {16{8'h0F}};
    localparam logic [127:0] X3C     = {16{8'h3C}};
    localparam logic [127:0] XF0     = {16{8'hF0}};

    int lanes_of [3] = '{1, 2, 4};
    int ncyc_of  [3] = '{4, 2, 1};

    aria_diff_seq #(.LANES(1)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dir(dir), .i_perm_pat(perm_pat),
        .i_din(din), .i_acc_clr(acc_clr), .i_xfb_load(xfb_load), .i_xfb_din(xfb_din),
        .o_busy(busy[0]), .o_done(done[0]), .o_dout(dout[0]));
    aria_diff_seq #(.LANES(2)) u_l2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dir(dir), .i_perm_pat(perm_pat),
        .i_din(din), .i_acc_clr(acc_clr), .i_xfb_load(xfb_load), .i_xfb_din(xfb_din),
        .o_busy(busy[1]), .o_done(done[1]), .o_dout(dout[1]));
    aria_diff_seq #(.LANES(4)) u_l4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dir(dir), .i_perm_pat(perm_pat),
        .i_din(din), .i_acc_clr(acc_clr), .i_xfb_load(xfb_load), .i_xfb_din(xfb_din),
        .o_busy(busy[2]), .o_done(done[2]), .o_dout(dout[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_dout(input string tag, input logic [127:0] exp);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_L%0d", tag, lanes_of[k]), dout[k], exp);
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk_all_dout("clr_dout", '0);
    endtask

    // Start one operation; optionally inject start/xfb_load on the first step edge.
    task automatic run_op(input string tag, input logic [127:0] d, input logic dv,
                          input logic [3:0] pat, input logic inj_start,
                          input logic inj_xfb, input logic [127:0] exp);
        int           lat   [3];
        int           ndone [3];
        int           nbusy [3];
        logic [127:0] val   [3];
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; ndone[k] = 0; nbusy[k] = 0; val[k] = 'x;
        end
        din = d; dir = dv; perm_pat = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) if (busy[k]) nbusy[k]++;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin
                start    = inj_start;
                xfb_load = inj_xfb;
                din      = (inj_start || inj_xfb) ? ONES : d;
                dir      = ~dv;
                perm_pat = ~pat;
                xfb_din  = X3C;
            end else begin
                start    = 1'b0;
                xfb_load = 1'b0;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    ndone[k]++;
                    if (lat[k] == 0) begin
                        lat[k] = c;
                        val[k] = dout[k];
                    end
                end
                if (busy[k]) nbusy[k]++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_lat_L%0d", tag, lanes_of[k]), 128'(lat[k]), 128'(ncyc_of[k]));
            chk($sformatf("%s_ndone_L%0d", tag, lanes_of[k]), 128'(ndone[k]), 128'd1);
            chk($sformatf("%s_nbusy_L%0d", tag, lanes_of[k]), 128'(nbusy[k]), 128'(ncyc_of[k]));
            chk($sformatf("%s_dout_L%0d", tag, lanes_of[k]), val[k], exp);
        end
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; perm_pat = '0; din = '0;
        acc_clr = 1'b0; xfb_load = 1'b0; xfb_din = '0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy_L%0d", lanes_of[k]), 128'(busy[k]), '0);
            chk($sformatf("rst_done_L%0d", lanes_of[k]), 128'(done[k]), '0);
        end
        chk_all_dout("rst_dout", '0);
        rst_n = 1'b1;
        tick();

        run_op("t1_zero", '0, 1'b0, 4'b0000, 1'b0, 1'b0, '0);

        run_op("t2_even", A_MSB, 1'b0, 4'b1111, 1'b0, 1'b0, EXP_T2);
        clear_acc();
        run_op("t2_odd_startbusy", A_MSB, 1'b0, 4'b0000, 1'b1, 1'b0, EXP_T2);
        clear_acc();
        run_op("t3_mixed", A_MSB, 1'b0, 4'b0001, 1'b0, 1'b0, EXP_T3);
        clear_acc();
        run_op("t4_dir1", B_LSB, 1'b1, 4'b1111, 1'b0, 1'b0, EXP_T2);
        clear_acc();

        din = ONES; xfb_din = X0F; xfb_load = 1'b1;
        tick();
        xfb_load = 1'b0;
        chk_all_dout("t5_xfb", XF0);
        run_op("t5_rev_xfbbusy", '0, 1'b0, 4'b1111, 1'b0, 1'b1, XF0);
        clear_acc();

        // acc_clr on the second step edge of the LANES=1 instance
        din = A_MSB; dir = 1'b0; perm_pat = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_step0_L1", dout[0], EXP_S0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("t6_clr_dout_L1", dout[0], '0);
        chk("t6_clr_busy_L1", 128'(busy[0]), '0);
        nd = int'(done[0]) + int'(done[1]);
        for (int c = 0; c < 5; c++) begin
            tick();
            nd += int'(done[0]) + int'(done[1]);
        end
        chk("t6_no_done", 128'(nd), '0);

        // asynchronous reset in the middle of an operation
        din = A_MSB; perm_pat = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_rst_busy_L%0d", lanes_of[k]), 128'(busy[k]), '0);
            chk($sformatf("t6_rst_done_L%0d", lanes_of[k]), 128'(done[k]), '0);
        end
        chk_all_dout("t6_rst_dout", '0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
